// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add sequencer and its slice adder.
package wide_add_pkg;

  localparam int unsigned SLICE_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} wadd_state_t;

  // Width of the per-operation slice counter.
  function automatic int unsigned cnt_width(input int unsigned nslice);
    return (nslice < 2) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/wide_add_sequencer_ks_adder.sv
// 32-bit Kogge-Stone parallel-prefix adder with carry in/out.
module wide_add_sequencer_ks_adder
  import wide_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               cout_o
);

  localparam int unsigned LEVELS = $clog2(SLICE_W);

  logic [SLICE_W-1:0] carry;

  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    if (l == 0) begin : base
      // Cin is folded into bit 0's generate so the prefix tree yields carries directly
      assign g = {a_i[SLICE_W-1:1] & b_i[SLICE_W-1:1],
                  (a_i[0] & b_i[0]) | ((a_i[0] ^ b_i[0]) & cin_i)};
      assign p = a_i ^ b_i;
    end else begin : merge
      localparam int unsigned D = 1 << (l - 1);
      // Combine each (g,p) pair with the one D positions below it
      always_comb begin
        for (int unsigned i = 0; i < SLICE_W; i++) begin
          if (i >= D) begin
            g[i] = lvl[l-1].g[i] | (lvl[l-1].p[i] & lvl[l-1].g[i-D]);
            p[i] = lvl[l-1].p[i] & lvl[l-1].p[i-D];
          end else begin
            g[i] = lvl[l-1].g[i];
            p[i] = lvl[l-1].p[i];
          end
        end
      end
    end
  end

  assign carry  = {lvl[LEVELS].g[SLICE_W-2:0], cin_i};
  assign s_o    = lvl[0].p ^ carry;
  assign cout_o = lvl[LEVELS].g[SLICE_W-1];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: feeds one 32-bit slice per cycle through a shared
// Kogge-Stone adder, chaining carries, and returns the full-width result.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int unsigned NSLICE = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SLICE_W*NSLICE-1:0]   a,
  input  logic [SLICE_W*NSLICE-1:0]   b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SLICE_W*NSLICE-1:0]   sum,
  output logic                        cout,
  output logic                        ovf
);

  localparam int unsigned SLICE = SLICE_W;
  localparam int unsigned TOTAL = SLICE * NSLICE;
  localparam int unsigned CNT_W = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  wadd_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [TOTAL-1:0] opa_q, opa_d;
  logic [TOTAL-1:0] opb_q, opb_d;
  logic [TOTAL-1:0] acc_q, acc_d;
  logic [TOTAL-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;

  logic [SLICE-1:0] ks_s;
  logic             ks_cout;

  wide_add_sequencer_ks_adder u_ks (
    .a_i    (opa_q[SLICE-1:0]),
    .b_i    (opb_q[SLICE-1:0]),
    .cin_i  (carry_q),
    .s_o    (ks_s),
    .cout_o (ks_cout)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Next-state and datapath update for the IDLE/RUN/DONE sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          amsb_d  = a[TOTAL-1];
          bmsb_d  = b[TOTAL-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Slices accumulate in a separate shifter so sum/cout/ovf stay stable until completion
        acc_d   = {ks_s, acc_q[TOTAL-1:SLICE]};
        opa_d   = opa_q >> SLICE;
        opb_d   = opb_q >> SLICE;
        carry_d = ks_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = ks_cout;
          ovf_d   = (amsb_q == bmsb_q) && (ks_s[SLICE-1] != amsb_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
    end
  end

endmodule
